// File: rtl/bomber_info_panel_draw_if.sv
// Side-channel bus of the info-panel drawer.
//   char_addr/char_line : glyph fetch towards the shared char ROM
//   rom_word            : ROM row, returned one clock after the address
//   stat_sel            : selects which player's status word is presented
//   stat_data           : packed status word of the selected player
// master = the drawer, slave = the ROM / status source.
interface bomber_info_panel_draw_if #(
  parameter int X_ADDR_WIDTH = 5,
  parameter int Y_ADDR_WIDTH = 3,
  parameter int SEL_W        = 1
);
  logic [X_ADDR_WIDTH+Y_ADDR_WIDTH-1:0] char_addr;
  logic [3:0]                           char_line;
  logic [7:0]                           rom_word;
  logic [SEL_W-1:0]                     stat_sel;
  logic [13:0]                          stat_data;

  modport master (
    output char_addr, char_line, stat_sel,
    input  rom_word, stat_data
  );

  modport slave (
    input  char_addr, char_line, stat_sel,
    output rom_word, stat_data
  );
endinterface

// File: rtl/bomber_info_panel_draw.sv
// Player-status text panels overlaid on the VGA stream.
// Ports:
//   i_pclk, i_rst           : pixel clock, synchronous active-high reset
//   i_hcount..i_rgb         : incoming VGA timing, coordinates and colour
//   o_hcount..o_rgb         : same stream delayed 3 clk, panels drawn in
//   bus (master)            : char-ROM fetch and per-player status fetch
// A fetch sequence at every vblank start copies each player's status into
// shadow registers; drawing only ever reads the shadows.
module bomber_info_panel_draw #(
  parameter int          N_PANELS      = 2,
  parameter int          SEL_W         = 1,
  parameter int          X_ADDR_WIDTH  = 5,
  parameter int          Y_ADDR_WIDTH  = 3,
  parameter int          SCALE_COEFF   = 0,
  parameter int          X_CHAR_COUNT  = 20,
  parameter int          Y_CHAR_COUNT  = 5,
  parameter int          XPOS          = 16,
  parameter int          YPOS          = 16,
  parameter int          PANEL_PITCH   = 120,
  parameter int          DIGITS_OFFSET = 192,
  parameter logic [11:0] FG_RGB        = 12'hfff,
  parameter logic [11:0] BG_RGB        = 12'h66e,
  parameter int          FLASH_FRAMES  = 32
) (
  input  logic        i_pclk,
  input  logic        i_rst,
  input  logic [11:0] i_hcount,
  input  logic [11:0] i_vcount,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_hblnk,
  input  logic        i_vblnk,
  input  logic [11:0] i_rgb,
  output logic [11:0] o_hcount,
  output logic [11:0] o_vcount,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_hblnk,
  output logic        o_vblnk,
  output logic [11:0] o_rgb,
  bomber_info_panel_draw_if.master bus
);
  localparam int AW = X_ADDR_WIDTH + Y_ADDR_WIDTH;
  localparam int S  = SCALE_COEFF;
  localparam int PW = X_CHAR_COUNT * (8 << S);
  localparam int PH = Y_CHAR_COUNT * (16 << S);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_PANELS - 1);

  typedef enum logic [1:0] {IDLE, ADDR, CAPT} state_t;

  typedef struct packed {
    logic [11:0] hcount;
    logic [11:0] vcount;
    logic        hsync;
    logic        vsync;
    logic        hblnk;
    logic        vblnk;
  } timing_t;

  typedef struct packed {
    logic [11:0]      rgb;
    logic             hit;
    logic [SEL_W-1:0] pan;
    logic [2:0]       px;
  } draw_t;

  // ---------------- status fetch ----------------
  state_t           state, state_nxt;
  logic [SEL_W-1:0] idx;
  logic             vblnk_q;
  logic [13:0]      shadow    [N_PANELS];
  logic [7:0]       flash_cnt [N_PANELS];
  logic             fetch_start;

  assign fetch_start  = i_vblnk && !vblnk_q;
  assign bus.stat_sel = idx;

  always_ff @(posedge i_pclk) begin
    if (i_rst) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (fetch_start) state_nxt = ADDR;
      ADDR:    state_nxt = CAPT;
      CAPT:    state_nxt = (idx == LAST_IDX) ? IDLE : ADDR;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      idx     <= '0;
      vblnk_q <= 1'b0;
      for (int unsigned k = 0; k < N_PANELS; k++) begin
        shadow[k]    <= '0;
        flash_cnt[k] <= '0;
      end
    end else begin
      vblnk_q <= i_vblnk;
      if (state == IDLE && fetch_start) idx <= '0;
      if (state == CAPT) begin
        shadow[idx] <= bus.stat_data;
        // A lost life (re)starts the flash; otherwise age it once per frame.
        if (bus.stat_data[11:10] < shadow[idx][11:10])
          flash_cnt[idx] <= 8'(FLASH_FRAMES);
        else if (flash_cnt[idx] != '0)
          flash_cnt[idx] <= flash_cnt[idx] - 8'd1;
        if (idx != LAST_IDX) idx <= idx + 1'b1;
      end
    end
  end

  // ---------------- stage 0: panel hit and glyph address ----------------
  logic [31:0]      hc, vc, relx, rely, col, row, dig_val;
  logic             hit, is_dig;
  logic [SEL_W-1:0] pan;
  logic [13:0]      sh_sel;
  logic [AW-1:0]    addr0;
  timing_t          tm0, tm1, tm2, tm3;
  draw_t            dr0, dr1, dr2;

  always_comb begin
    hc   = 32'(i_hcount);
    vc   = 32'(i_vcount);
    hit  = 1'b0;
    pan  = '0;
    rely = '0;
    // Ascending scan with first-hit latch: lowest panel wins on overlap.
    for (int unsigned k = 0; k < N_PANELS; k++) begin
      if (!hit && hc >= 32'(XPOS) && hc < 32'(XPOS + PW) &&
          vc >= 32'(YPOS) + k * 32'(PANEL_PITCH) &&
          vc <  32'(YPOS + PH) + k * 32'(PANEL_PITCH)) begin
        hit  = 1'b1;
        pan  = SEL_W'(k);
        rely = vc - (32'(YPOS) + k * 32'(PANEL_PITCH));
      end
    end
    relx    = hit ? (hc - 32'(XPOS)) : '0;
    col     = relx >> (3 + S);
    row     = rely >> (4 + S);
    sh_sel  = shadow[pan];
    is_dig  = 1'b1;
    dig_val = '0;
    if      (col == 8  && row == 0) dig_val = 32'(pan) + 32'd1;
    else if (col == 11 && row == 2) dig_val = 32'(sh_sel[0]);
    else if (col == 12 && row == 2) dig_val = 32'(sh_sel[4:1]);
    else if (col == 15 && row == 2) dig_val = 32'(sh_sel[5]);
    else if (col == 16 && row == 2) dig_val = 32'(sh_sel[9:6]);
    else if (col == 7  && row == 3) dig_val = 32'(sh_sel[11:10]);
    else if (col == 7  && row == 4) dig_val = 32'(sh_sel[13:12]);
    else                            is_dig  = 1'b0;
    addr0 = is_dig ? AW'(32'(DIGITS_OFFSET) + dig_val)
                   : {row[Y_ADDR_WIDTH-1:0], col[X_ADDR_WIDTH-1:0]};

    tm0.hcount = i_hcount;
    tm0.vcount = i_vcount;
    tm0.hsync  = i_hsync;
    tm0.vsync  = i_vsync;
    tm0.hblnk  = i_hblnk;
    tm0.vblnk  = i_vblnk;
    dr0.rgb    = i_rgb;
    dr0.hit    = hit;
    dr0.pan    = pan;
    dr0.px     = relx[2+S:S];
  end

  // ---------------- stage 3: colour select ----------------
  logic        pix, swap;
  logic [11:0] fg, bg, rgb_nxt;

  always_comb begin
    pix  = bus.rom_word[3'd7 - dr2.px];
    swap = (flash_cnt[dr2.pan] != '0) && flash_cnt[dr2.pan][2];
    fg   = swap ? BG_RGB : FG_RGB;
    bg   = swap ? FG_RGB : BG_RGB;
    if (tm2.hblnk || tm2.vblnk) rgb_nxt = '0;
    else if (dr2.hit)           rgb_nxt = pix ? fg : bg;
    else                        rgb_nxt = dr2.rgb;
  end

  always_ff @(posedge i_pclk) begin
    if (i_rst) begin
      tm1           <= '0;
      tm2           <= '0;
      tm3           <= '0;
      dr1           <= '0;
      dr2           <= '0;
      bus.char_addr <= '0;
      bus.char_line <= '0;
      o_rgb         <= '0;
    end else begin
      tm1           <= tm0;
      tm2           <= tm1;
      tm3           <= tm2;
      dr1           <= dr0;
      dr2           <= dr1;
      bus.char_addr <= addr0;
      bus.char_line <= rely[3+S:S];
      o_rgb         <= rgb_nxt;
    end
  end

  assign o_hcount = tm3.hcount;
  assign o_vcount = tm3.vcount;
  assign o_hsync  = tm3.hsync;
  assign o_vsync  = tm3.vsync;
  assign o_hblnk  = tm3.hblnk;
  assign o_vblnk  = tm3.vblnk;
endmodule

// File: tb/tb_bomber_info_panel_draw.sv
// Randomized bench for bomber_info_panel_draw: two instances (normal and
// overlapping panel pitch) share the VGA input; a behavioural model predicts
// glyph addresses, timing delays and colours per pixel.
module tb_bomber_info_panel_draw;
  localparam int N = 2, XW = 5, YW = 3, S = 0, XCC = 20, YCC = 5;
  localparam int XPOS = 16, YPOS = 16, PITCH = 120, PITCH_OV = 40;
  localparam int DOFF = 192, FF = 32, FG = 'hfff, BG = 'h66e;

  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;

  logic [11:0] hc = '0, vc = '0, rgb_in = '0;
  logic        hs = 1'b0, vs = 1'b0, hb = 1'b0, vb = 1'b0;
  logic [11:0] o_hcount_a, o_vcount_a, o_rgb_a, o_hcount_b, o_vcount_b, o_rgb_b;
  logic        o_hsync_a, o_vsync_a, o_hblnk_a, o_vblnk_a;
  logic        o_hsync_b, o_vsync_b, o_hblnk_b, o_vblnk_b;
  logic [13:0] stat_tab [N];

  bomber_info_panel_draw_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .SEL_W(1)) bus_a ();
  bomber_info_panel_draw_if #(.X_ADDR_WIDTH(XW), .Y_ADDR_WIDTH(YW), .SEL_W(1)) bus_b ();

  bomber_info_panel_draw #(.N_PANELS(N), .SEL_W(1), .PANEL_PITCH(PITCH), .FLASH_FRAMES(FF)) u_dut (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hc), .i_vcount(vc), .i_hsync(hs), .i_vsync(vs),
    .i_hblnk(hb), .i_vblnk(vb), .i_rgb(rgb_in), .o_hcount(o_hcount_a), .o_vcount(o_vcount_a),
    .o_hsync(o_hsync_a), .o_vsync(o_vsync_a), .o_hblnk(o_hblnk_a), .o_vblnk(o_vblnk_a),
    .o_rgb(o_rgb_a), .bus(bus_a));

  bomber_info_panel_draw #(.N_PANELS(N), .SEL_W(1), .PANEL_PITCH(PITCH_OV), .FLASH_FRAMES(FF)) u_dut_ovl (
    .i_pclk(clk), .i_rst(rst), .i_hcount(hc), .i_vcount(vc), .i_hsync(hs), .i_vsync(vs),
    .i_hblnk(hb), .i_vblnk(vb), .i_rgb(rgb_in), .o_hcount(o_hcount_b), .o_vcount(o_vcount_b),
    .o_hsync(o_hsync_b), .o_vsync(o_vsync_b), .o_hblnk(o_hblnk_b), .o_vblnk(o_vblnk_b),
    .o_rgb(o_rgb_b), .bus(bus_b));

  // Bench-owned char ROM contents and status sources.
  function automatic int rom_model(input int addr, input int line);
    return ((addr * 29 + line * 7) ^ (addr >> 2) ^ (line << 4)) & 255;
  endfunction

  always @(posedge clk) bus_a.rom_word <= 8'(rom_model(int'(bus_a.char_addr), int'(bus_a.char_line)));
  always @(posedge clk) bus_b.rom_word <= 8'(rom_model(int'(bus_b.char_addr), int'(bus_b.char_line)));
  assign bus_a.stat_data = stat_tab[bus_a.stat_sel];
  assign bus_b.stat_data = stat_tab[bus_b.stat_sel];

  int n_checks = 0, n_fail = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int sh [N];
  int fl [N];

  function automatic void model_pix(input int pitch, input int h, input int v, input bit blank,
                                    input int rgb, output bit inp, output int addr,
                                    output int line, output int orgb);
    int cw, ch, k, rx, ry, col, row, val, pc, bitv, swap;
    bit dig;
    cw = 8 << S; ch = 16 << S; k = -1;
    for (int i = 0; i < N; i++)
      if (k < 0 && h >= XPOS && h < XPOS + XCC * cw &&
          v >= YPOS + i * pitch && v < YPOS + i * pitch + YCC * ch) k = i;
    inp = (k >= 0); addr = 0; line = 0;
    if (!inp) begin
      orgb = blank ? 0 : rgb;
      return;
    end
    rx = h - XPOS; ry = v - (YPOS + k * pitch);
    col = rx / cw; row = ry / ch;
    dig = 1; val = 0;
    if      (col == 8  && row == 0) val = k + 1;
    else if (col == 11 && row == 2) val = sh[k] % 2;
    else if (col == 12 && row == 2) val = (sh[k] / 2) % 16;
    else if (col == 15 && row == 2) val = (sh[k] / 32) % 2;
    else if (col == 16 && row == 2) val = (sh[k] / 64) % 16;
    else if (col == 7  && row == 3) val = (sh[k] / 1024) % 4;
    else if (col == 7  && row == 4) val = (sh[k] / 4096) % 4;
    else dig = 0;
    addr = dig ? DOFF + val : (row % (1 << YW)) * (1 << XW) + col % (1 << XW);
    line = (ry >> S) % 16;
    pc   = (rx >> S) % 8;
    bitv = (rom_model(addr, line) >> (7 - pc)) & 1;
    swap = (fl[k] / 4) % 2;
    if (blank) orgb = 0;
    else       orgb = ((bitv ^ swap) != 0) ? FG : BG;
  endfunction

  typedef struct {
    bit v;
    int h, vv, sync;
    bit in_a, in_b;
    int addr_a, line_a, addr_b, line_b, rgb_a, rgb_b;
  } exp_t;

  exp_t hist [4];
  int   sn = 0;
  int   dcol [7] = '{8, 11, 12, 15, 16, 7, 7};
  int   drow [7] = '{0, 2, 2, 2, 2, 3, 4};

  // One pixel clock: check outputs due now, then drive the next input.
  task automatic step(input int h, input int v, input bit hbv, input bit vbv);
    exp_t e;
    int   rgbv;
    bit   hsv, vsv;
    @(negedge clk);
    if (rst) for (int i = 0; i < 4; i++) hist[i].v = 0;
    e = hist[(sn + 3) % 4];
    if (sn >= 1 && e.v) begin
      if (e.in_a) begin
        check_eq("char_addr_a", bus_a.char_addr, e.addr_a);
        check_eq("char_line_a", bus_a.char_line, e.line_a);
      end
      if (e.in_b) begin
        check_eq("char_addr_b", bus_b.char_addr, e.addr_b);
        check_eq("char_line_b", bus_b.char_line, e.line_b);
      end
    end
    e = hist[(sn + 1) % 4];
    if (sn >= 3 && e.v) begin
      check_eq("hcount", o_hcount_a, e.h);
      check_eq("vcount", o_vcount_a, e.vv);
      check_eq("sync", {o_hsync_a, o_vsync_a, o_hblnk_a, o_vblnk_a}, e.sync);
      check_eq("rgb_a", o_rgb_a, e.rgb_a);
      check_eq("rgb_b", o_rgb_b, e.rgb_b);
    end
    rgbv = $urandom_range(0, 4095);
    hsv  = 1'($urandom_range(0, 1));
    vsv  = 1'($urandom_range(0, 1));
    hc = 12'(h); vc = 12'(v); hb = hbv; vb = vbv; hs = hsv; vs = vsv; rgb_in = 12'(rgbv);
    e.v = !rst; e.h = h; e.vv = v; e.sync = {28'd0, hsv, vsv, hbv, vbv};
    model_pix(PITCH,    h, v, hbv | vbv, rgbv, e.in_a, e.addr_a, e.line_a, e.rgb_a);
    model_pix(PITCH_OV, h, v, hbv | vbv, rgbv, e.in_b, e.addr_b, e.line_b, e.rgb_b);
    hist[sn % 4] = e;
    sn++;
  endtask

  task automatic pix_rand();
    int h, v, i, k;
    if ($urandom_range(0, 2) == 0) begin
      i = $urandom_range(0, 6);
      k = $urandom_range(0, N - 1);
      h = XPOS + dcol[i] * 8 + $urandom_range(0, 7);
      v = YPOS + k * PITCH + drow[i] * 16 + $urandom_range(0, 15);
    end else begin
      h = $urandom_range(0, 199);
      v = $urandom_range(0, 239);
    end
    step(h, v, ($urandom_range(0, 7) == 0), 1'b0);
  endtask

  task automatic frame(input logic [13:0] s0, input logic [13:0] s1, input bit do_reset);
    int nl, ol;
    stat_tab[0] = s0; stat_tab[1] = s1;
    step(0, 0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b0);
    step(0, 0, 1'b1, 1'b1);
    if (do_reset) begin
      step(0, 0, 1'b1, 1'b1);
      step(0, 0, 1'b1, 1'b1);
      rst = 1'b1;
      repeat (3) step(0, 0, 1'b1, 1'b1);
      check_eq("rst_rgb", o_rgb_a, 0);
      check_eq("rst_hcount", o_hcount_a, 0);
      check_eq("rst_stat_sel", bus_a.stat_sel, 0);
      check_eq("rst_char_addr", bus_a.char_addr, 0);
      step(0, 0, 1'b1, 1'b0);
      rst = 1'b0;
      for (int k = 0; k < N; k++) begin sh[k] = 0; fl[k] = 0; end
    end else begin
      for (int j = 1; j <= 2 * N + 1; j++) begin
        step(0, 0, 1'b1, 1'b1);
        if (j % 2 == 1) check_eq("stat_sel", bus_a.stat_sel, (j <= 2 * N) ? (j - 1) / 2 : N - 1);
      end
      for (int k = 0; k < N; k++) begin
        nl = (stat_tab[k] / 1024) % 4;
        ol = (sh[k] / 1024) % 4;
        if (nl < ol)     fl[k] = FF;
        else if (fl[k] > 0) fl[k] = fl[k] - 1;
        sh[k] = int'(stat_tab[k]);
      end
      repeat (3) step(0, 0, 1'b1, 1'b1);
      step(0, 0, 1'b1, 1'b0);
    end
  endtask

  initial begin
    logic [13:0] s0;
    int lives;
    for (int k = 0; k < N; k++) begin sh[k] = 0; fl[k] = 0; stat_tab[k] = '0; end
    repeat (3) step(0, 0, 1'b0, 1'b0);
    check_eq("init_rgb", o_rgb_a, 0);
    check_eq("init_stat_sel", bus_a.stat_sel, 0);
    check_eq("init_hcount", o_hcount_a, 0);
    rst = 1'b0;
    step(XPOS, YPOS, 1'b0, 1'b0);
    for (int f = 0; f < 47; f++) begin
      if (f == 0) frame(14'h1C05, 14'h0000, 1'b0);
      else if (f == 45) frame(14'(0 + $urandom), 14'(0 + $urandom), 1'b1);
      else begin
        if (f == 1) lives = 2;
        else if (f <= 37) lives = 2;
        else if (f == 38) lives = 3;
        else lives = -1;
        s0 = 14'($urandom);
        if (lives >= 0) s0 = (s0 & 14'h33ff) | 14'(lives << 10);
        frame(s0, 14'($urandom), 1'b0);
      end
      if (f == 0) begin
        step(XPOS, YPOS, 1'b0, 1'b0);
        step(XPOS + 7 * 8, YPOS + 3 * 16, 1'b0, 1'b0);
        step(XPOS + 8 * 8, YPOS + PITCH, 1'b0, 1'b0);
        step(XPOS + 8 * 8, YPOS + PITCH_OV, 1'b0, 1'b0);
        step(300, 300, 1'b0, 1'b0);
        step(300, 300, 1'b1, 1'b0);
      end
      repeat (60) pix_rand();
    end
    repeat (4) step(0, 0, 1'b1, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/bomber_info_panel_draw.md
Name: bomber_info_panel_draw

Overview:
- Draws N_PANELS stacked player-status text panels over the incoming VGA stream, one panel per player.
- At each vertical-blank start it fetches every player's packed status word through a sequential select/capture sequence into frame-coherent shadow registers.
- Renders the fixed text layout plus digit fields (ID, X/Y position, lives, bombs) from a shared char ROM.
- When a player loses a life, that panel flashes (fg/bg swap) for FLASH_FRAMES frames.
- Sits in the VGA pipeline after the board/sprite drawers and before the output register stage.

Parameters:
- N_PANELS, 2, number of panels/players (1..4).
- SEL_W, 1, width of o_stat_sel; equals clog2(N_PANELS), minimum 1.
- X_ADDR_WIDTH, 5, column bits of the text-ROM address.
- Y_ADDR_WIDTH, 3, row bits of the text-ROM address.
- SCALE_COEFF, 0, character scale as a log2 multiplier; char is (8<<S) x (16<<S) pixels.
- X_CHAR_COUNT, 20, panel width in characters.
- Y_CHAR_COUNT, 5, panel height in characters.
- XPOS, 16, panel left pixel.
- YPOS, 16, top pixel of panel 0.
- PANEL_PITCH, 120, vertical pixel offset between consecutive panels.
- DIGITS_OFFSET, 192, char-ROM address of glyph '0'.
- FG_RGB, 12'hfff, glyph colour.
- BG_RGB, 12'h66e, panel background colour.
- FLASH_FRAMES, 32, flash duration in frames, 1..255.

Ports:
- i_pclk  in  1  pixel clock
- i_rst  in  1  synchronous active-high reset
- i_hcount, i_vcount  in  12 each  pixel coordinates
- i_hsync, i_vsync, i_hblnk, i_vblnk  in  1 each  timing signals
- i_rgb  in  12  upstream pixel colour
- i_rom_word  in  8  char-ROM row, valid 1 clk after o_char_addr/o_char_line
- i_stat_data  in  14  status word of the selected player
  - [0] X tens digit, [4:1] X units digit
  - [5] Y tens digit, [9:6] Y units digit
  - [11:10] lives, [13:12] bombs
- o_hcount, o_vcount  out  12 each  delayed coordinates
- o_hsync, o_vsync, o_hblnk, o_vblnk  out  1 each  delayed timing signals
- o_rgb  out  12  output pixel colour
- o_char_addr  out  X_ADDR_WIDTH+Y_ADDR_WIDTH  char-ROM address
- o_char_line  out  4  glyph row
- o_stat_sel  out  SEL_W  status-source select

Behaviour:
- Reset is i_rst, synchronous, active-high, on clock i_pclk. Under reset:
  - all outputs are 0; o_rgb is 12'h000.
  - shadows and flash counters are cleared; the FSM goes to IDLE.
  - reset asserted mid-fetch aborts the fetch; shadows stay 0 until the next vblank.
- Pipeline:
  - All timing and coordinate outputs are their inputs delayed exactly 3 clk.
  - o_char_addr and o_char_line are registered at latency 1.
  - The ROM returns data at latency 2.
  - o_rgb is registered at latency 3.
- Panel k (0..N-1) covers:
  - hcount in [XPOS, XPOS+W), with W = X_CHAR_COUNT*(8<<S).
  - vcount in [YPOS+k*PANEL_PITCH, +H), with H = Y_CHAR_COUNT*(16<<S).
  - If panels overlap, the lowest k wins.
- Relative coordinates (rel) are measured from the hit panel's origin. Character column col = relx>>(3+S); character row row = rely>>(4+S).
- Digit fields (col,row) select glyph DIGITS_OFFSET+value:
  - ID at (8,0) shows k+1.
  - X tens at (11,2), X units at (12,2).
  - Y tens at (15,2), Y units at (16,2).
  - Lives at (7,3), bombs at (7,4).
  - Values come from shadow[k], zero-extended.
- Outside the digit fields, o_char_addr = {row[Y_ADDR_WIDTH-1:0], col[X_ADDR_WIDTH-1:0]}.
- o_char_line = rely[3+S:S]. The pixel bit is i_rom_word[7 - relx[2+S:S]], using the latency-aligned relx.
- Colour, evaluated at latency 3:
  - Blanking (hblnk or vblnk) gives 12'h000.
  - Inside panel k: bit=1 gives FG_RGB, else BG_RGB. When flash_cnt[k]!=0 and flash_cnt[k][2]==1, FG and BG are swapped.
  - Otherwise the delayed i_rgb passes through.
- Fetch FSM states are IDLE, ADDR, CAPT.
  - IDLE -> ADDR on the i_vblnk rising edge (i_vblnk=1, previous=0); k=0.
  - ADDR: drive o_stat_sel=k for one clk, then go to CAPT.
  - CAPT: latch i_stat_data into shadow[k]. Then go to ADDR with k+1, or to IDLE if k==N_PANELS-1.
  - o_stat_sel holds its last value in IDLE.
  - The sequence takes 2*N_PANELS clk. It runs to completion even if vblank ends.
  - A new vblank rising edge during a fetch is ignored.
- Flash counters, updated in the CAPT step for panel k only:
  - If new lives < old shadow lives, flash_cnt[k] loads FLASH_FRAMES.
  - Else, if flash_cnt[k]!=0, it decrements by 1.
  - The counter saturates at 0.
  - Lives increasing or unchanged never starts a flash.
- Drawing uses shadows only, so a panel never shows data that changed mid-frame.

Test Plan:
1. Reset for 3 clk mid-fetch, release → o_rgb=000, o_stat_sel=0, FSM idle; panel 0 shows zeros next frame.
2. Single pixel at hcount=XPOS, vcount=YPOS, no blank → o_hcount=XPOS exactly 3 clk later; o_char_addr=0 1 clk after input.
3. Vblank rising edge with N_PANELS=2, stat=14'h1C05 for sel 0 and 14'h0000 for sel 1 → o_stat_sel steps 0 then 1 over 4 clk. Panel 0 lives cell shows o_char_addr=195; panel 1 ID cell shows 194.
4. Lives 3 then 2 on consecutive frames, FLASH_FRAMES=32 → panel 0 glyph pixels render BG_RGB/FG_RGB swapped while flash_cnt[2]=1; flash ends 32 frames later. Lives 2 then 3 gives no flash.
5. Pixel outside all panels with i_rgb=12'h0a5 → o_rgb=0a5. The same pixel with hblnk=1 → o_rgb=000.
6. Panels overlapping (PANEL_PITCH=40) → overlap region shows panel 0 with ID glyph 193.
